pipe_mem_stage: RTL
===================

PIPE_MEM_STAGE -- requirements
Module: pipe_mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the max wait cycles for dmem_ack (used only under MEM_TIMEOUT_EN).
REQ-002 SHALL have one clock and asynchronous active-low reset, ports listed first: clock in 1 rising-edge clock; resetn in 1 async active-low reset.
REQ-003 SHALL have ports: evalid in 1 EX instruction valid; ewreg in 1 regfile write; em2reg in 1 load; ewmem in 1 store.
REQ-004 SHALL have ports: ealu in 32 ALU result/address; eb in 32 store data; ern in 5 dest register.
REQ-005 SHALL have ports: stall out 1 hold EX and upstream stages.
REQ-006 SHALL have ports: dmem_req out 1; dmem_we out 1; dmem_addr out 32; dmem_wdata out 32; dmem_rdata in 32; dmem_ack in 1.
REQ-007 SHALL have ports: wwreg out 1; wm2reg out 1; walu out 32; wmo out 32; wrn out 5, forming the MEM/WB register.
REQ-008 SHALL have port mem_err out 1, sticky timeout flag.

Function
REQ-009 SHALL hold an EX/MEM register (mvalid, mwreg, mm2reg, mwmem, malu, mb, mrn) that loads all E inputs on a rising edge when stall=0 and holds when stall=1.
REQ-010 SHALL define memop = mvalid & (mm2reg | mwmem).
REQ-011 SHALL implement FSM IDLE/BUSY: BUSY whenever the loaded instruction is a memop and not yet complete; IDLE otherwise.
REQ-012 SHALL in BUSY drive dmem_req=1, dmem_we=mwmem, dmem_addr=malu, dmem_wdata=mb, all stable until ack; in IDLE dmem_req=0, dmem_we=0.
REQ-013 SHALL drive stall = BUSY & ~dmem_ack, combinationally.
REQ-014 SHALL treat ack seen in BUSY as completion; ack in IDLE SHALL be ignored.
REQ-015 SHALL allow zero-wait ack: ack in the first BUSY cycle completes the access in one cycle.
REQ-016 SHALL define complete = (mvalid & ~memop) | (BUSY & dmem_ack).
REQ-017 SHALL on complete load wwreg=mwreg, wm2reg=mm2reg, walu=malu, wrn=mrn, and wmo=dmem_rdata for loads (wmo unchanged otherwise).
REQ-018 SHALL on a cycle without complete load wwreg=0 and wm2reg=0 (bubble); walu/wmo/wrn hold.
REQ-019 SHALL give latency: non-memop reaches MEM/WB one cycle after entering EX/MEM; memop one cycle after its ack.
REQ-020 SHALL on ack, with a memop waiting in EX, load it and re-enter BUSY with no IDLE cycle between.

Reset
REQ-021 SHALL on resetn=0 asynchronously clear all EX/MEM and MEM/WB fields, mem_err, and the timeout counter, and force IDLE.
REQ-022 SHALL on reset mid-access drop dmem_req immediately; the access SHALL NOT complete or be retried.

Configuration
REQ-023 SHALL with MEM_TIMEOUT_EN defined count BUSY cycles; on reaching TIMEOUT_CYCLES without ack, set mem_err=1 (sticky until reset), force complete as bubble (wwreg=0), and go IDLE.
REQ-024 SHALL reset the counter to 0 on every entry to BUSY, and SHALL let an ack on the final cycle win over timeout.
REQ-025 SHALL without MEM_TIMEOUT_EN wait for ack indefinitely, tie mem_err to 0, and have no counter.

Structure
REQ-026 SHALL take the FSM state encoding (IDLE=0, BUSY=1) and the default TIMEOUT_CYCLES constant from shared package pipe_pkg.
REQ-027 SHALL place the timeout counter in sub-module pipe_mem_timer, instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-028 SHALL cover ALU op: ewreg=1, ealu=0x1234, ern=5 -> stall never 1; two edges later wwreg=1, walu=0x1234, wrn=5.
REQ-029 SHALL cover load with 3-cycle ack delay: ealu=0x100, rdata=0xDEADBEEF -> stall high 3 cycles, dmem_addr=0x100 held; next edge wmo=0xDEADBEEF, wm2reg=1.
REQ-030 SHALL cover zero-wait store: eb=0xA5A5A5A5, ack in the same cycle -> dmem_we=1, dmem_wdata=0xA5A5A5A5, stall=0, wwreg=0.
REQ-031 SHALL cover back-to-back loads, each acked after 1 cycle -> dmem_req stays high across both; two completions, in order.
REQ-032 SHALL cover a spurious ack in IDLE -> no state change and no MEM/WB load.
REQ-033 SHALL cover, under MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack: mem_err=1 after 4 BUSY cycles, bubble then IDLE; and resetn low mid-access: dmem_req=0 immediately, all outputs 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared MEM-stage types: FSM encoding, default timeout and the EX/MEM register layout.
package pipe_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mem_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef struct packed {
    logic        valid;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  rn;
  } exmem_t;

  function automatic logic is_memop(input exmem_t r);
    return r.valid & (r.m2reg | r.wmem);
  endfunction

endpackage

// File: rtl/pipe_mem_timer.sv
// Counts consecutive BUSY cycles without ack; expire pulses on the last allowed cycle.
module pipe_mem_timer
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic busy,
  input  logic ack,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // An ack on the final cycle wins, so expire is masked by ack.
  assign expire = busy & ~ack & (cnt == LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                   cnt <= '0;
    else if (!busy || ack || expire) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM pipeline stage: EX/MEM register, single-outstanding data-memory handshake, MEM/WB register.
// Optional access timeout with sticky mem_err when MEM_TIMEOUT_EN is defined.
module pipe_mem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        evalid,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] walu,
  output logic [31:0] wmo,
  output logic [4:0]  wrn,
  output logic        mem_err
);

  exmem_t     m;
  mem_state_e state;
  logic       busy, memop, complete, timeout;

  assign busy       = (state == BUSY);
  assign memop      = is_memop(m);
  assign stall      = busy & ~dmem_ack;
  assign complete   = (m.valid & ~memop) | (busy & dmem_ack);
  assign dmem_req   = busy;
  assign dmem_we    = busy & m.wmem;
  assign dmem_addr  = m.alu;
  assign dmem_wdata = m.b;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m      <= '0;
      state  <= IDLE;
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      walu   <= '0;
      wmo    <= '0;
      wrn    <= '0;
    end else begin
      if (!stall) begin
        m     <= '{valid: evalid, wreg: ewreg, m2reg: em2reg, wmem: ewmem,
                   alu: ealu, b: eb, rn: ern};
        // Going straight from one ack into the next access keeps req high.
        state <= (evalid & (em2reg | ewmem)) ? BUSY : IDLE;
      end else if (timeout) begin
        state <= IDLE;
      end
      if (complete) begin
        wwreg  <= m.wreg;
        wm2reg <= m.m2reg;
        walu   <= m.alu;
        wrn    <= m.rn;
        if (m.m2reg) wmo <= dmem_rdata;
      end else begin
        wwreg  <= 1'b0;
        wm2reg <= 1'b0;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  pipe_mem_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock  (clock),
    .resetn (resetn),
    .busy   (busy),
    .ack    (dmem_ack),
    .expire (timeout)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)      mem_err <= 1'b0;
    else if (timeout) mem_err <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

endmodule
